ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, start request, bit-serial frame, ACK capture.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_CLK  = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [INH_W-1:0] r_inh_cnt;
    logic [INH_W-1:0] w_inh_cnt_next;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_next;
    logic [9:0]       r_frame;
    logic [9:0]       w_frame_next;
    logic             r_clk_oe;
    logic             w_clk_oe_next;
    logic             r_dat_oe;
    logic             w_dat_oe_next;
    logic             r_done;
    logic             w_done_next;
    logic             r_ack;
    logic             w_ack_next;
    logic             r_ready_en;
    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_d;
    logic             r_dat_s1;
    logic             r_dat_s2;
    logic             w_clk_fall;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic [WD_W-1:0] w_wd_cnt_next;
    logic            r_error;
    logic            w_error_next;
`endif

    assign w_clk_fall = r_clk_d & ~r_clk_s2;

    // Valid/ready: a byte transfers on any rising edge where cmd_valid and cmd_ready are both 1;
    // cmd_ready is high only in IDLE, so offers made while busy are simply not taken.
    assign cmd_ready   = (r_state == S_IDLE) && r_ready_en;
    assign busy        = (r_state != S_IDLE);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_dat_oe  = r_dat_oe;
    assign done        = r_done;
    assign ack_ok      = r_ack;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_next   = r_state;
        w_inh_cnt_next = r_inh_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_frame_next   = r_frame;
        w_dat_oe_next  = r_dat_oe;
        w_done_next    = 1'b0;
        w_ack_next     = r_ack;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        w_wd_cnt_next  = r_wd_cnt;
        w_error_next   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_dat_oe_next = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    w_state_next   = S_INHIBIT;
                    w_inh_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    // Frame shifts out LSB first: data[7:0], odd parity, stop (released).
                    w_frame_next   = {1'b1, ~^cmd_data, cmd_data};
                    w_ack_next     = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    w_state_next  = S_REQ;
                    w_dat_oe_next = 1'b1;
                end else begin
                    w_inh_cnt_next = r_inh_cnt + INH_W'(1);
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT_CLK;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                w_wd_cnt_next = '0;
`endif
            end
            S_WAIT_CLK: begin
                if (w_clk_fall) begin
                    if (r_bit_cnt == 4'd10) begin
                        w_ack_next    = ~r_dat_s2;
                        w_dat_oe_next = 1'b0;
                        w_state_next  = S_WAIT_IDLE;
                    end else begin
                        w_dat_oe_next  = ~r_frame[0];
                        w_frame_next   = r_frame >> 1;
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_dat_oe_next = 1'b0;
            end
        endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog overrides the normal flow once the device has had long enough to respond.
        if (r_state == S_WAIT_CLK || r_state == S_WAIT_IDLE) begin
            if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                w_error_next  = 1'b1;
                w_done_next   = 1'b0;
                w_dat_oe_next = 1'b0;
                w_state_next  = S_IDLE;
            end else begin
                w_wd_cnt_next = r_wd_cnt + WD_W'(1);
            end
        end
`endif
        w_clk_oe_next = (w_state_next == S_INHIBIT) || (w_state_next == S_REQ);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_frame    <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
            r_ready_en <= 1'b0;
            // Idle bus level, so leaving reset never looks like a falling edge.
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_d    <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_inh_cnt  <= w_inh_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_frame    <= w_frame_next;
            r_clk_oe   <= w_clk_oe_next;
            r_dat_oe   <= w_dat_oe_next;
            r_done     <= w_done_next;
            r_ack      <= w_ack_next;
            r_ready_en <= 1'b1;
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_d    <= r_clk_s2;
            r_dat_s1   <= ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_cnt_next;
            r_error  <= w_error_next;
        end
    end

    assign error = r_error;
`else
    // No watchdog in this build: TIMEOUT_CYCLES has no effect and error is constant 0.
    assign error = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 device model, frame reference model, directed + random transfers.
module tb_ps2_host_tx;

  localparam int INHIBIT    = 5000;
  localparam int TB_TIMEOUT = 3000;
  localparam int HALF       = 15;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic [2:0] dbg_state;
  logic       dev_clk;
  logic       dev_dat;
  logic       ps2_clk_in;
  logic       ps2_dat_in;

  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic       last_ack = 1'b0;
  logic [9:0] exp_q[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  // Open-collector bus: either side may pull a line low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .error      (error),
    .o_dbg_state(dbg_state)
  );

  always @(negedge CLOCK_50) begin
    if (done === 1'b1) begin
      done_cnt++;
      last_ack = ack_ok;
    end
    if (error === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Wire order of the frame the device should see: data LSB first, odd parity, stop = 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    int n;
    int m;
    cmd_data  = b;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      wait_cyc(1);
      n++;
    end
    chk("ready_wait", 32'(n < 1000), 1);
    wait_cyc(1);
    cmd_valid = 1'b0;
    chk("busy_after_capture", {busy, cmd_ready}, 2'b10);
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < 20000) begin
      n++;
      wait_cyc(1);
    end
    chk("inhibit_len", n, INHIBIT);
    m = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1 && m < 100) begin
      m++;
      wait_cyc(1);
    end
    chk("req_len", m, 1);
    chk("after_req_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  task automatic dev_xfer(input bit do_ack, input int abort_at, input bit poke, output logic [9:0] got);
    got = '0;
    wait_cyc(HALF);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      wait_cyc(HALF);
      if (k == abort_at) begin
        dev_clk = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      wait_cyc(2);
      got[k-1] = ps2_dat_in;
      if (poke && k == 3) begin
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        wait_cyc(1);
        chk("poke_ignored", {busy, cmd_ready}, 2'b10);
        cmd_valid = 1'b0;
        wait_cyc(HALF - 3);
      end else begin
        wait_cyc(HALF - 2);
      end
    end
    if (do_ack) dev_dat = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic full_xfer(input logic [7:0] b, input bit do_ack, input bit poke);
    logic [9:0] got;
    logic [9:0] exp;
    int d0;
    int n;
    exp_q.push_back(model_frame(b));
    d0 = done_cnt;
    send_cmd(b);
    dev_xfer(do_ack, 0, poke, got);
    exp = exp_q.pop_front();
    chk($sformatf("frame_%02h", b), got, exp);
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      wait_cyc(1);
      n++;
    end
    chk("done_seen", 32'(n < 100), 1);
    chk("ack_ok", last_ack, do_ack);
    wait_cyc(10);
    chk("done_once", done_cnt - d0, 1);
    chk("idle_after", {busy, cmd_ready, ps2_clk_oe, ps2_dat_oe}, 4'b0100);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [9:0] got;
    int d0;
    int e0;
    int c;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    dev_clk   = 1'b1;
    dev_dat   = 1'b1;
    wait_cyc(3);
    chk("reset_outputs", {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok, error}, 7'b0);
    reset = 1'b1;
    wait_cyc(1);
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);

    full_xfer(8'hF4, 1'b1, 1'b0);
    full_xfer(8'hFF, 1'b0, 1'b0);
    full_xfer(8'hA5, 1'b1, 1'b1);

    // Reset after falling edge 5, then a clean retry.
    d0 = done_cnt;
    send_cmd(8'hF4);
    dev_xfer(1'b1, 5, 1'b0, got);
    reset = 1'b0;
    wait_cyc(1);
    chk("abort_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("abort_flags", {busy, cmd_ready, done, error}, 4'b0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(1);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    full_xfer(8'hF4, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      full_xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'h12);
    c = 0;
    while (error !== 1'b1 && c < TB_TIMEOUT + 100) begin
      wait_cyc(1);
      c++;
    end
    chk("timeout_len", c, TB_TIMEOUT);
    chk("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    wait_cyc(1);
    chk("timeout_ready", cmd_ready, 1);
    chk("timeout_err_once", err_cnt - e0, 1);
    chk("timeout_no_done", done_cnt - d0, 0);
    full_xfer(8'hF4, 1'b1, 1'b0);
`else
    e0 = 0;
    c = 0;
    chk("no_error_pulses", err_cnt + e0 + c, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
